set_access_controller: RTL and testbench
========================================

// Module: set_access_controller
// PURPOSE
//  Initiator side of the cache-set access interface. Accepts CPU load/store requests on a
//  valid/ready channel and splits each address into tag/index/offset. Drives one set
//  operation per request: enable, write_enable, block_offset, data_size, tag, write_data, n_ops.
//  Collects out_data/miss/data_ready and returns a single response per request on a
//  valid/ready channel. Sits between the core LSU and the array of Set instances.
// PARAMETERS
//  ADDR_W    32  CPU byte address width
//  TAG_W     24  tag width; tag = addr[31:8]
//  INDEX_W   2   set-select width; index = addr[7:6]; NUM_SETS = 4
//  OFFSET_W  6   block byte offset; offset = addr[5:0] (64-byte blocks)
//  DATA_W    64  max access width
//  TIMEOUT   16  max WAIT cycles for a read before error response
// PORTS
//  clk              in   1    single clock, all logic posedge
//  reset            in   1    synchronous, active-high
//  cpu_req_valid    in   1    request present
//  cpu_req_ready    out  1    controller accepts request (IDLE only)
//  cpu_req_addr     in   32   byte address
//  cpu_req_we       in   1    1=store, 0=load
//  cpu_req_size     in   2    0:8b 1:16b 2:32b 3:64b
//  cpu_req_wdata    in   64   store data, right-aligned
//  cpu_rsp_valid    out  1    response present
//  cpu_rsp_ready    in   1    consumer accepts response
//  cpu_rsp_data     out  64   load data, zero-extended above access size; 0 for stores
//  cpu_rsp_miss     out  1    set reported tag miss
//  cpu_rsp_err      out  1    misaligned request or read timeout
//  set_sel          out  4    one-hot set select, decoded from index
//  set_enable       out  1    set operation strobe (one cycle)
//  set_write_enable out  3    0=read 1=write 2=no-op
//  set_block_offset out  6    byte offset within block
//  set_data_size    out  2    copy of cpu_req_size
//  set_tag          out  24   tag for lookup
//  set_write_data   out  64   store data
//  set_n_ops        out  32   operation sequence number
//  set_out_data     in   129  read data from set, bit 0 = first returned bit
//  set_miss         in   1    tag miss
//  set_data_ready   in   1    read data valid
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except set_write_enable=2 (no-op); op counter=0.
//   Reset mid-operation aborts it; no response is issued for the aborted request.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//   IDLE: cpu_req_ready=1. On valid&ready, register all request fields.
//    Misaligned (offset % 2**size != 0) -> RESP with err=1; no set op, counter unchanged.
//    Else -> ISSUE.
//   ISSUE: set_enable=1 and set_sel valid for exactly one cycle; set_n_ops=counter;
//    counter increments at end of cycle, wrapping 0xFFFFFFFF->0. -> WAIT.
//   WAIT: set_enable=0; set_* address/data held stable.
//    Read: set_data_ready (has priority over set_miss) -> capture
//     out_data[8*2**size-1:0] into rsp_data, -> RESP.
//     set_miss -> miss=1, data=0, -> RESP. TIMEOUT cycles with neither -> err=1, -> RESP.
//    Write: exactly one WAIT cycle; miss=set_miss sampled then, -> RESP.
//   RESP: cpu_rsp_valid=1; data/miss/err held stable until cpu_rsp_ready, then -> IDLE
//    and response fields clear. cpu_req_ready stays 0 in RESP, so a new request is
//    accepted no earlier than the cycle after the handshake.
//  Latency: aligned hit read = 4 cycles from accept to rsp_valid (+ set response delay);
//   misaligned = 2 cycles.
//  cpu_rsp_miss and cpu_rsp_err are never both 1.
// STRUCTURE
//  cache_pkg: op encodings (OP_READ=0, OP_WRITE=1, OP_NOP=2), size encodings,
//   state enum, TAG/INDEX/OFFSET field positions.
//  Sub-module addr_split: combinational tag/index/offset split, one-hot set_sel, alignment flag.
// TESTING
//  1. Store addr=0x00000F48 size=3 wdata=0xDEADBEEFCAFEF00D -> one ISSUE cycle, tag=0x00000F,
//     sel=4'b0010, offset=8, write_enable=1, n_ops=0; rsp miss=0 err=0.
//  2. Load same addr size=2, set_data_ready next cycle with out_data=0x...CAFEF00D ->
//     rsp_data=0x00000000CAFEF00D, n_ops=1.
//  3. Load addr=0x00000003 size=1 -> no set_enable pulse, rsp err=1, counter unchanged.
//  4. Load with set_miss=1 in WAIT -> rsp miss=1 data=0; with no set response for 16 cycles
//     -> rsp err=1.
//  5. Hold cpu_rsp_ready=0 for 5 cycles -> rsp fields stable, cpu_req_ready=0; reset
//     asserted during WAIT -> next cycle all outputs reset, no response.
//  6. Preload counter to 0xFFFFFFFF, issue two ops -> set_n_ops 0xFFFFFFFF then 0.

Source files
------------

// File: rtl/set_access_controller_pkg.sv
// Shared encodings and address field layout for the cache-set access controller.
package set_access_controller_pkg;
    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 24;
    localparam int INDEX_W    = 2;
    localparam int OFFSET_W   = 6;
    localparam int DATA_W     = 64;
    localparam int NUM_SETS   = 4;
    localparam int SET_DATA_W = 129;

    localparam int TAG_LSB    = 8;
    localparam int INDEX_LSB  = 6;
    localparam int OFFSET_LSB = 0;

    typedef enum logic [2:0] {OP_READ = 3'd0, OP_WRITE = 3'd1, OP_NOP = 3'd2} op_e;
    typedef enum logic [1:0] {SIZE_8 = 2'd0, SIZE_16 = 2'd1, SIZE_32 = 2'd2, SIZE_64 = 2'd3} size_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    // Keeps only the bytes covered by the access; upper bits are zero-extended.
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_8:  return 64'h0000_0000_0000_00FF;
            SIZE_16: return 64'h0000_0000_0000_FFFF;
            SIZE_32: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction
endpackage

// File: rtl/set_access_controller_addr_split.sv
// Combinational tag/index/offset split with one-hot set select and natural-alignment check.
module set_access_controller_addr_split
    import set_access_controller_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    output logic [TAG_W-1:0]    tag,
    output logic [NUM_SETS-1:0] sel,
    output logic [OFFSET_W-1:0] offset,
    output logic                aligned
);
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] amask;

    assign tag    = addr[TAG_LSB +: TAG_W];
    assign index  = addr[INDEX_LSB +: INDEX_W];
    assign offset = addr[OFFSET_LSB +: OFFSET_W];
    assign sel    = {{(NUM_SETS-1){1'b0}}, 1'b1} << index;

    always_comb begin
        amask = '0;
        case (size)
            SIZE_8:  amask = 6'b000000;
            SIZE_16: amask = 6'b000001;
            SIZE_32: amask = 6'b000011;
            default: amask = 6'b000111;
        endcase
    end

    assign aligned = ((offset & amask) == '0);
endmodule

// File: rtl/set_access_controller.sv
// Initiator side of the cache-set interface: one set operation and one CPU response per request.
module set_access_controller
    import set_access_controller_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] OPS_INIT = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [ADDR_W-1:0]     cpu_req_addr,
    input  logic                  cpu_req_we,
    input  logic [1:0]            cpu_req_size,
    input  logic [DATA_W-1:0]     cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    input  logic                  cpu_rsp_ready,
    output logic [DATA_W-1:0]     cpu_rsp_data,
    output logic                  cpu_rsp_miss,
    output logic                  cpu_rsp_err,
    output logic [NUM_SETS-1:0]   set_sel,
    output logic                  set_enable,
    output logic [2:0]            set_write_enable,
    output logic [OFFSET_W-1:0]   set_block_offset,
    output logic [1:0]            set_data_size,
    output logic [TAG_W-1:0]      set_tag,
    output logic [DATA_W-1:0]     set_write_data,
    output logic [31:0]           set_n_ops,
    input  logic [SET_DATA_W-1:0] set_out_data,
    input  logic                  set_miss,
    input  logic                  set_data_ready
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_e              state;
    logic                we_q;
    logic [1:0]          size_q;
    logic [31:0]         ops_cnt;
    logic [WCNT_W-1:0]   wait_cnt;

    logic [TAG_W-1:0]    tag;
    logic [NUM_SETS-1:0] sel;
    logic [OFFSET_W-1:0] offset;
    logic                aligned;
    logic                unused_hi;

    // Only the low DATA_W bits of the set data path can ever be returned.
    assign unused_hi = ^set_out_data[SET_DATA_W-1:DATA_W];

    set_access_controller_addr_split u_split (
        .addr    (cpu_req_addr),
        .size    (cpu_req_size),
        .tag     (tag),
        .sel     (sel),
        .offset  (offset),
        .aligned (aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            we_q             <= 1'b0;
            size_q           <= '0;
            ops_cnt          <= OPS_INIT;
            wait_cnt         <= '0;
            cpu_req_ready    <= 1'b0;
            cpu_rsp_valid    <= 1'b0;
            cpu_rsp_data     <= '0;
            cpu_rsp_miss     <= 1'b0;
            cpu_rsp_err      <= 1'b0;
            set_sel          <= '0;
            set_enable       <= 1'b0;
            set_write_enable <= OP_NOP;
            set_block_offset <= '0;
            set_data_size    <= '0;
            set_tag          <= '0;
            set_write_data   <= '0;
            set_n_ops        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_req_ready <= 1'b1;
                    if (cpu_req_valid && cpu_req_ready) begin
                        cpu_req_ready    <= 1'b0;
                        we_q             <= cpu_req_we;
                        size_q           <= cpu_req_size;
                        set_tag          <= tag;
                        set_block_offset <= offset;
                        set_data_size    <= cpu_req_size;
                        set_write_data   <= cpu_req_wdata;
                        if (!aligned) begin
                            state         <= ST_RESP;
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_err   <= 1'b1;
                        end else begin
                            state            <= ST_ISSUE;
                            set_enable       <= 1'b1;
                            set_sel          <= sel;
                            set_n_ops        <= ops_cnt;
                            set_write_enable <= cpu_req_we ? OP_WRITE : OP_READ;
                        end
                    end
                end
                ST_ISSUE: begin
                    set_enable <= 1'b0;
                    set_sel    <= '0;
                    ops_cnt    <= ops_cnt + 32'd1;
                    wait_cnt   <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Writes finish after a single WAIT cycle; reads wait for data, miss or timeout.
                    if (we_q) begin
                        cpu_rsp_miss <= set_miss;
                        state        <= ST_RESP;
                    end else if (set_data_ready) begin
                        cpu_rsp_data <= set_out_data[DATA_W-1:0] & size_mask(size_q);
                        state        <= ST_RESP;
                    end else if (set_miss) begin
                        cpu_rsp_miss <= 1'b1;
                        state        <= ST_RESP;
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        cpu_rsp_err <= 1'b1;
                        state       <= ST_RESP;
                    end
                    if (we_q || set_data_ready || set_miss || wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        cpu_rsp_valid    <= 1'b1;
                        set_write_enable <= OP_NOP;
                    end
                end
                ST_RESP: begin
                    if (cpu_rsp_ready) begin
                        state         <= ST_IDLE;
                        cpu_rsp_valid <= 1'b0;
                        cpu_rsp_data  <= '0;
                        cpu_rsp_miss  <= 1'b0;
                        cpu_rsp_err   <= 1'b0;
                        cpu_req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_set_access_controller.sv
// Directed bench for set_access_controller; a second instance starts its op counter at 0xFFFFFFFF.
module tb_set_access_controller;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req_valid = 1'b0;
    logic [31:0]  cpu_req_addr = '0;
    logic         cpu_req_we = 1'b0;
    logic [1:0]   cpu_req_size = '0;
    logic [63:0]  cpu_req_wdata = '0;
    logic         cpu_rsp_ready = 1'b0;
    logic [128:0] set_out_data = '0;
    logic         set_miss = 1'b0;
    logic         set_data_ready = 1'b0;

    logic         cpu_req_ready, cpu_rsp_valid, cpu_rsp_miss, cpu_rsp_err, set_enable;
    logic [63:0]  cpu_rsp_data, set_write_data;
    logic [3:0]   set_sel;
    logic [2:0]   set_write_enable;
    logic [5:0]   set_block_offset;
    logic [1:0]   set_data_size;
    logic [23:0]  set_tag;
    logic [31:0]  set_n_ops;

    logic         w_req_ready, w_rsp_valid, w_rsp_miss, w_rsp_err, w_enable;
    logic [63:0]  w_rsp_data, w_write_data;
    logic [3:0]   w_sel;
    logic [2:0]   w_write_enable;
    logic [5:0]   w_block_offset;
    logic [1:0]   w_data_size;
    logic [23:0]  w_tag;
    logic [31:0]  w_n_ops;

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    set_access_controller dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
        .cpu_req_size(cpu_req_size), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_miss(cpu_rsp_miss), .cpu_rsp_err(cpu_rsp_err),
        .set_sel(set_sel), .set_enable(set_enable), .set_write_enable(set_write_enable),
        .set_block_offset(set_block_offset), .set_data_size(set_data_size),
        .set_tag(set_tag), .set_write_data(set_write_data), .set_n_ops(set_n_ops),
        .set_out_data(set_out_data), .set_miss(set_miss), .set_data_ready(set_data_ready)
    );

    set_access_controller #(.OPS_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(w_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
        .cpu_req_size(cpu_req_size), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(w_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_data(w_rsp_data), .cpu_rsp_miss(w_rsp_miss), .cpu_rsp_err(w_rsp_err),
        .set_sel(w_sel), .set_enable(w_enable), .set_write_enable(w_write_enable),
        .set_block_offset(w_block_offset), .set_data_size(w_data_size),
        .set_tag(w_tag), .set_write_data(w_write_data), .set_n_ops(w_n_ops),
        .set_out_data(set_out_data), .set_miss(set_miss), .set_data_ready(set_data_ready)
    );

    always @(posedge clk) if (set_enable === 1'b1) en_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                          input logic [63:0] wdata);
        int n = 0;
        while (!cpu_req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 64'(cpu_req_ready), 64'd1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        cpu_req_we    = we;
        cpu_req_size  = size;
        cpu_req_wdata = wdata;
        tick();
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [63:0] data, input logic miss,
                            input logic err);
        int n = 0;
        while (!cpu_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(cpu_rsp_valid), 64'd1);
        chk({tag, "_data"}, cpu_rsp_data, data);
        chk({tag, "_miss"}, 64'(cpu_rsp_miss), 64'(miss));
        chk({tag, "_err"}, 64'(cpu_rsp_err), 64'(err));
        cpu_rsp_ready = 1'b1;
        tick();
        cpu_rsp_ready = 1'b0;
        chk({tag, "_valid_clr"}, 64'(cpu_rsp_valid), 64'd0);
        chk({tag, "_err_clr"}, 64'(cpu_rsp_err), 64'd0);
    endtask

    initial begin
        int en0;
        int n;
        repeat (2) tick();
        chk("rst_req_ready", 64'(cpu_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
        chk("rst_enable", 64'(set_enable), 64'd0);
        chk("rst_we", 64'(set_write_enable), 64'd2);
        chk("rst_n_ops", 64'(set_n_ops), 64'd0);
        chk("rst_sel", 64'(set_sel), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_req_ready", 64'(cpu_req_ready), 64'd1);

        // Store, 8 bytes at 0xF48
        do_req(32'h0000_0F48, 1'b1, 2'd3, 64'hDEAD_BEEF_CAFE_F00D);
        chk("st_enable", 64'(set_enable), 64'd1);
        chk("st_tag", 64'(set_tag), 64'h0F);
        chk("st_sel", 64'(set_sel), 64'b0010);
        chk("st_offset", 64'(set_block_offset), 64'd8);
        chk("st_we", 64'(set_write_enable), 64'd1);
        chk("st_size", 64'(set_data_size), 64'd3);
        chk("st_wdata", set_write_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("st_n_ops", 64'(set_n_ops), 64'd0);
        chk("st_req_ready", 64'(cpu_req_ready), 64'd0);
        tick();
        chk("st_wait_enable", 64'(set_enable), 64'd0);
        chk("st_wait_tag", 64'(set_tag), 64'h0F);
        chk("st_wait_offset", 64'(set_block_offset), 64'd8);
        tick();
        wait_rsp("st", 64'd0, 1'b0, 1'b0);

        // Load 4 bytes at same address; data_ready in first WAIT cycle
        do_req(32'h0000_0F48, 1'b0, 2'd2, 64'd0);
        chk("ld_we", 64'(set_write_enable), 64'd0);
        chk("ld_n_ops", 64'(set_n_ops), 64'd1);
        tick();
        set_data_ready = 1'b1;
        set_out_data   = {1'b1, 64'hFFFF_0000_0000_0000, 64'h1122_3344_CAFE_F00D};
        tick();
        set_data_ready = 1'b0;
        chk("ld_we_nop", 64'(set_write_enable), 64'd2);
        wait_rsp("ld", 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0);

        // Misaligned 16-bit load: error without any set operation
        en0 = en_cnt;
        do_req(32'h0000_0003, 1'b0, 2'd1, 64'd0);
        chk("mis_fast_valid", 64'(cpu_rsp_valid), 64'd1);
        chk("mis_enable", 64'(set_enable), 64'd0);
        wait_rsp("mis", 64'd0, 1'b0, 1'b1);
        chk("mis_no_pulse", 64'(en_cnt), 64'(en0));

        // Read miss
        do_req(32'h0000_0040, 1'b0, 2'd0, 64'd0);
        chk("miss_n_ops", 64'(set_n_ops), 64'd2);
        chk("miss_sel", 64'(set_sel), 64'b0010);
        tick();
        set_miss = 1'b1;
        tick();
        set_miss = 1'b0;
        wait_rsp("miss", 64'd0, 1'b1, 1'b0);

        // data_ready wins over a simultaneous miss; 16-bit zero-extension
        do_req(32'h0000_0082, 1'b0, 2'd1, 64'd0);
        chk("pri_n_ops", 64'(set_n_ops), 64'd3);
        chk("pri_sel", 64'(set_sel), 64'b0100);
        chk("pri_offset", 64'(set_block_offset), 64'd2);
        tick();
        set_miss = 1'b1;
        set_data_ready = 1'b1;
        set_out_data = {65'd0, 64'h5555_AAAA_ABCD_1234};
        tick();
        set_miss = 1'b0;
        set_data_ready = 1'b0;
        wait_rsp("pri", 64'h0000_0000_0000_1234, 1'b0, 1'b0);

        // Read timeout: 16 WAIT cycles, RESP seen 17 cycles after ISSUE
        do_req(32'h0000_00C0, 1'b0, 2'd3, 64'd0);
        chk("to_n_ops", 64'(set_n_ops), 64'd4);
        chk("to_sel", 64'(set_sel), 64'b1000);
        n = 0;
        while (!cpu_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", 64'(n), 64'd17);
        wait_rsp("to", 64'd0, 1'b0, 1'b1);

        // Response held while consumer stalls
        do_req(32'h0000_0100, 1'b0, 2'd3, 64'd0);
        chk("stall_n_ops", 64'(set_n_ops), 64'd5);
        chk("stall_tag", 64'(set_tag), 64'h01);
        tick();
        set_data_ready = 1'b1;
        set_out_data = {65'd0, 64'h0123_4567_89AB_CDEF};
        tick();
        set_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(cpu_rsp_valid), 64'd1);
            chk("stall_data", cpu_rsp_data, 64'h0123_4567_89AB_CDEF);
            chk("stall_req_ready", 64'(cpu_req_ready), 64'd0);
            tick();
        end
        wait_rsp("stall", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // Reset during WAIT aborts the load without a response
        do_req(32'h0000_01C0, 1'b0, 2'd2, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
        chk("abort_enable", 64'(set_enable), 64'd0);
        chk("abort_we", 64'(set_write_enable), 64'd2);
        chk("abort_n_ops", 64'(set_n_ops), 64'd0);
        chk("abort_tag", 64'(set_tag), 64'd0);
        chk("abort_req_ready", 64'(cpu_req_ready), 64'd0);
        reset = 1'b0;
        set_data_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_rsp_valid) n++;
        end
        set_data_ready = 1'b0;
        chk("abort_no_rsp", 64'(n), 64'd0);

        // Counter restart and wraparound on the preloaded instance
        do_req(32'h0000_0200, 1'b1, 2'd0, 64'h0000_0000_0000_00A5);
        chk("wrap0_main", 64'(set_n_ops), 64'd0);
        chk("wrap0", 64'(w_n_ops), 64'hFFFF_FFFF);
        repeat (2) tick();
        wait_rsp("wst0", 64'd0, 1'b0, 1'b0);
        do_req(32'h0000_0241, 1'b1, 2'd0, 64'h0000_0000_0000_005A);
        chk("wrap1_main", 64'(set_n_ops), 64'd1);
        chk("wrap1", 64'(w_n_ops), 64'd0);
        chk("wrap1_sel", 64'(set_sel), 64'b0010);
        tick();
        set_miss = 1'b1;
        tick();
        set_miss = 1'b0;
        wait_rsp("wst1", 64'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
